// File: rtl/combination_input_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : combination_input_conditioner                                 |
// | Purpose  : Turns two raw, asynchronous, bouncy push-buttons into clean   |
// |            one-cycle "0"/"1" symbol pulses for the combination lock FSM. |
// |            Each button has a 2-flop synchroniser, a debounce counter,    |
// |            and a registered edge detect. A shared press FSM drives the   |
// |            registered pulses. Presses of both buttons at the same time   |
// |            or overlapping are rejected.                                  |
// | Ports    : clk          - single rising-edge clock                       |
// |            rst          - asynchronous active-high reset                 |
// |            btn_zero_raw - raw "0" button (async, active-high, bouncy)    |
// |            btn_one_raw  - raw "1" button (async, active-high, bouncy)    |
// |            zero         - one-cycle pulse, "0" symbol entered            |
// |            one          - one-cycle pulse, "1" symbol entered            |
// |            conflict     - one-cycle pulse on each rejected press         |
// |                           (present only with COMBO_IN_CONFLICT_EN)       |
// | Config   : `define COMBO_IN_CONFLICT_EN adds the conflict output.        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module combination_input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_zero_raw,
   input  logic btn_one_raw,
`ifdef COMBO_IN_CONFLICT_EN
   output logic conflict,
`endif
   output logic zero,
   output logic one
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   // A button already held when reset releases has its debounced level
   // climb from 0, which looks like a fresh press. That first rise can reach
   // the FSM no later than DEBOUNCE_CYCLES+4 edges after release, so rises
   // are masked until then.
   localparam int ST_LIM = DEBOUNCE_CYCLES + 4;
   localparam int ST_W   = $clog2(ST_LIM + 1);
   localparam logic [ST_W-1:0] ST_DONE = ST_W'(ST_LIM);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HELD   = 2'd1,
      REJECT = 2'd2
   } state_t;

   // Bit 0 = "0" button, bit 1 = "1" button.
   logic [1:0]       w_raw;
   logic [1:0]       s1_q;
   logic [1:0]       s2_q;
   logic [1:0]       deb_q;
   logic [1:0]       deb_dly_q;
   logic [1:0]       rise_q;
   logic [CNT_W-1:0] cnt_q [2];
   logic [ST_W-1:0]  st_q;
   logic [1:0]       w_rise;
   logic [1:0]       w_lvl;
   state_t           state_q;
   state_t           state_d;
   logic             zero_q;
   logic             zero_d;
   logic             one_q;
   logic             one_d;
`ifdef COMBO_IN_CONFLICT_EN
   logic             conf_q;
   logic             conf_d;
`endif

   assign w_raw = {btn_one_raw, btn_zero_raw};

   // Synchroniser, debounce counter and registered edge detect per button.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q      <= '0;
         s2_q      <= '0;
         deb_q     <= '0;
         deb_dly_q <= '0;
         rise_q    <= '0;
         cnt_q[0]  <= '0;
         cnt_q[1]  <= '0;
      end else begin
         s1_q      <= w_raw;
         s2_q      <= s1_q;
         deb_dly_q <= deb_q;
         // Rise is registered together with the delayed level so the FSM
         // sees the edge and both levels from the same instant.
         rise_q    <= deb_q & ~deb_dly_q;
         for (int b = 0; b < 2; b++) begin
            if (s2_q[b] != deb_q[b]) begin
               if (cnt_q[b] == CNT_MAX) begin
                  deb_q[b] <= s2_q[b];
                  cnt_q[b] <= '0;
               end else begin
                  cnt_q[b] <= cnt_q[b] + 1'b1;
               end
            end else begin
               cnt_q[b] <= '0;
            end
         end
      end
   end

   // Post-reset settling counter, saturates at ST_DONE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q <= '0;
      end else if (st_q != ST_DONE) begin
         st_q <= st_q + 1'b1;
      end
   end

   assign w_rise = rise_q & {2{st_q == ST_DONE}};
   assign w_lvl  = deb_dly_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         zero_q  <= 1'b0;
         one_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         zero_q  <= zero_d;
         one_q   <= one_d;
      end
   end

   always_comb begin
      state_d = state_q;
      zero_d  = 1'b0;
      one_d   = 1'b0;
`ifdef COMBO_IN_CONFLICT_EN
      conf_d  = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if ((w_rise[0] && w_rise[1]) ||
                (w_rise[0] && w_lvl[1])  ||
                (w_rise[1] && w_lvl[0])) begin
               state_d = REJECT;
`ifdef COMBO_IN_CONFLICT_EN
               conf_d  = 1'b1;
`endif
            end else if (w_rise[0]) begin
               zero_d  = 1'b1;
               state_d = HELD;
            end else if (w_rise[1]) begin
               one_d   = 1'b1;
               state_d = HELD;
            end
         end
         HELD: begin
            // The held button cannot rise again without first falling,
            // which would have returned us to IDLE; any rise is the other one.
            if (w_rise != 2'b00) begin
               state_d = REJECT;
`ifdef COMBO_IN_CONFLICT_EN
               conf_d  = 1'b1;
`endif
            end else if (w_lvl == 2'b00) begin
               state_d = IDLE;
            end
         end
         REJECT: begin
            if (w_lvl == 2'b00) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

`ifdef COMBO_IN_CONFLICT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         conf_q <= 1'b0;
      end else begin
         conf_q <= conf_d;
      end
   end

   assign conflict = conf_q;
`endif

   assign zero = zero_q;
   assign one  = one_q;

endmodule
`default_nettype wire
